// File: rtl/ysyx_22050612_pkg.sv
// Shared types and constants for the ysyx_22050612 core front end.
// Fetch entry layout and fetch FSM encoding live here.
package ysyx_22050612_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 64'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DISCARD,
        S_HALT
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic            fault;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_22050612_sync_fifo.sv
// Synchronous FIFO with flush; a push during flush becomes the sole entry.
// Push while full is accepted only when a pop happens in the same cycle.
module ysyx_22050612_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;
    logic [AW-1:0]    wr_addr;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (flush || !full || pop);
    assign wr_addr  = flush ? '0 : wr_ptr;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= AW'(do_push);
            count  <= CW'(do_push);
        end else begin
            rd_ptr <= rd_ptr + AW'(do_pop);
            wr_ptr <= wr_ptr + AW'(do_push);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_addr] <= push_data;
        end
    end

endmodule

// File: rtl/ysyx_22050612_fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, buffered results.
// Redirects flush the buffer and drop any in-flight response.
module ysyx_22050612_fetch_unit
    import ysyx_22050612_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_fault,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e state_q, state_d;
    logic [63:0]  fetch_pc_q, fetch_pc_d;
    logic [63:0]  req_pc_q, req_pc_d;
    logic         halt_q, halt_d;

    logic         fifo_flush;
    logic         fifo_push;
    fetch_entry_t push_entry;
    fetch_entry_t head;
    logic         fifo_full;
    logic         fifo_empty;
    logic [CW-1:0] fifo_count;
    logic         outstanding;
    logic         misaligned;
    logic         req_fire;

    // Request mask on redirect is combinational so no request races a flush.
    assign imem_req_valid = rst_n && (state_q == S_REQ)
                          && (fifo_count < CW'(DEPTH)) && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign outstanding    = (state_q == S_WAIT) || (state_q == S_DISCARD);
    assign misaligned     = |redirect_pc[1:0];

    assign out_valid = !fifo_empty;
    assign out_pc    = fifo_empty ? '0 : head.pc;
    assign out_inst  = fifo_empty ? '0 : head.inst;
    assign out_fault = !fifo_empty && head.fault;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        halt_d     = halt_q;
        fifo_flush = 1'b0;
        fifo_push  = 1'b0;
        push_entry = '0;
        if (redirect_valid) begin
            fifo_flush = 1'b1;
            fetch_pc_d = align4(redirect_pc);
            fifo_push  = misaligned;
            push_entry = '{pc: redirect_pc, inst: '0, fault: 1'b1};
            if (outstanding && !imem_resp_valid) begin
                state_d = S_DISCARD;
                halt_d  = misaligned;
            end else begin
                state_d = misaligned ? S_HALT : S_REQ;
                halt_d  = 1'b0;
            end
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        state_d    = S_WAIT;
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 64'd4;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        fifo_push  = 1'b1;
                        push_entry = '{pc: req_pc_q,
                                       inst: imem_resp_err ? '0 : imem_resp_data,
                                       fault: imem_resp_err};
                        state_d    = imem_resp_err ? S_HALT : S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (imem_resp_valid) begin
                        state_d = halt_q ? S_HALT : S_REQ;
                        halt_d  = 1'b0;
                    end
                end
                S_HALT: begin
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            halt_q     <= halt_d;
        end
    end

    ysyx_22050612_sync_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (fifo_flush),
        .push     (fifo_push),
        .push_data(push_entry),
        .pop      (out_valid && out_ready),
        .pop_data (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_ysyx_22050612_fetch_unit.sv
// Randomized bench for the fetch unit against a program-order stream model.
// Memory responds with a per-address word and optional fault address.
module tb_ysyx_22050612_fetch_unit;

    localparam logic [63:0] RPC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    always #5 clk = ~clk;

    ysyx_22050612_fetch_unit #(
        .RESET_PC(RPC),
        .DEPTH(2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .imem_resp_err  (imem_resp_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_fault      (out_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit          pend;
    logic [63:0] pend_addr;
    int          pend_cnt;
    int          lat_min = 1;
    int          lat_max = 1;
    int          rdy_pct = 100;
    bit          mem_block;
    bit          err_en;
    logic [63:0] err_addr;

    logic [63:0] exp_pc;
    logic [63:0] req_exp;
    bit          model_halt;
    bit          req_blocked;

    bit          o_fire, o_valid, r_fire, r_valid;
    logic [63:0] r_addr, last_pc;
    int          n_fire, n_req, n_fault;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'h5A3C_96E1;
    endfunction

    // One clock of stimulus: memory model, consumer, redirect, stream model.
    task automatic step(input logic rdy, input logic rv, input logic [63:0] rpc);
        logic        ef;
        logic [31:0] ei;
        @(negedge clk);
        cyc++;
        out_ready       = rdy;
        redirect_valid  = rv;
        redirect_pc     = rpc;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        imem_resp_err   = 1'b0;
        if (pend) begin
            if (pend_cnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = inst_of(pend_addr);
                imem_resp_err   = err_en && (pend_addr == err_addr);
                pend = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        imem_req_ready = !mem_block && (int'($urandom_range(0, 99)) < rdy_pct);
        #1;
        o_valid = out_valid;
        r_valid = imem_req_valid;
        r_addr  = imem_req_addr;
        r_fire  = imem_req_valid && imem_req_ready;
        o_fire  = out_valid && out_ready;
        if (o_fire) begin
            ef = (exp_pc[1:0] != 2'b00) || (err_en && exp_pc == err_addr);
            ei = ef ? 32'h0 : inst_of(exp_pc);
            total++;
            if (model_halt || out_pc !== exp_pc || out_inst !== ei || out_fault !== ef) begin
                bad++;
                $display("FAIL stream cyc=%0d got pc=%h inst=%h fault=%b want pc=%h inst=%h fault=%b halted=%0b",
                         cyc, out_pc, out_inst, out_fault, exp_pc, ei, ef, model_halt);
            end
            exp_pc  = exp_pc + 64'd4;
            last_pc = out_pc;
            if (ef) model_halt = 1'b1;
            n_fire++;
            if (out_fault) n_fault++;
        end
        if (r_fire) begin
            total++;
            if (rv || req_blocked || pend || r_addr !== req_exp) begin
                bad++;
                $display("FAIL req cyc=%0d got addr=%h want addr=%h redirect=%b blocked=%0b outstanding=%0b",
                         cyc, r_addr, req_exp, rv, req_blocked, pend);
            end
            if (err_en && r_addr == err_addr) req_blocked = 1'b1;
            req_exp   = req_exp + 64'd4;
            pend      = 1'b1;
            pend_addr = r_addr;
            pend_cnt  = int'($urandom_range(lat_min, lat_max)) - 1;
            n_req++;
        end
        if (rv) begin
            exp_pc      = rpc;
            model_halt  = 1'b0;
            req_exp     = {rpc[63:2], 2'b00};
            req_blocked = (rpc[1:0] != 2'b00);
        end
    endtask

    task automatic wait_req(input logic rdy, input int bound, input string nm);
        int k = 0;
        do begin
            step(rdy, 1'b0, '0);
            k++;
        end while (!r_fire && k < bound);
        total++;
        if (!r_fire) begin
            bad++;
            $display("FAIL %s_timeout got no request want request within %0d cycles", nm, bound);
        end
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got req=%b out=%b want 0 0", imem_req_valid, out_valid);
        end
        total++;
        if (out_pc !== 64'h0 || out_inst !== 32'h0 || out_fault !== 1'b0) begin
            bad++;
            $display("FAIL reset_out got pc=%h inst=%h fault=%b want zeros", out_pc, out_inst, out_fault);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_stream();
        int t0, f0, k;
        lat_min = 1; lat_max = 1; rdy_pct = 100;
        wait_req(1'b1, 10, "stream_first");
        total++;
        if (r_addr !== RPC) begin
            bad++;
            $display("FAIL first_addr got %h want %h", r_addr, RPC);
        end
        t0 = cyc;
        k  = 0;
        do begin
            step(1'b1, 1'b0, '0);
            k++;
        end while (!o_valid && k < 10);
        total++;
        if (cyc - t0 != 2) begin
            bad++;
            $display("FAIL first_latency got %0d want 2", cyc - t0);
        end
        f0 = n_fire;
        repeat (12) step(1'b1, 1'b0, '0);
        total++;
        if (n_fire - f0 < 3) begin
            bad++;
            $display("FAIL stream_rate got %0d want >=3", n_fire - f0);
        end
    endtask

    task automatic test_backpressure();
        int q0, f0;
        step(1'b0, 1'b1, 64'h8000_0400);
        q0 = n_req;
        repeat (10) step(1'b0, 1'b0, '0);
        total++;
        if (n_req - q0 != 2) begin
            bad++;
            $display("FAIL bp_reqs got %0d want 2", n_req - q0);
        end
        total++;
        if (r_valid !== 1'b0 || o_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_full got req_valid=%b out_valid=%b want 0 1", r_valid, o_valid);
        end
        f0 = n_fire;
        repeat (12) step(1'b1, 1'b0, '0);
        total++;
        if (n_fire - f0 < 2) begin
            bad++;
            $display("FAIL bp_release got %0d want >=2", n_fire - f0);
        end
    endtask

    task automatic test_redirect_wait();
        int f0;
        lat_min = 4; lat_max = 4;
        wait_req(1'b1, 10, "rw_first");
        lat_min = 1; lat_max = 1;
        step(1'b1, 1'b1, 64'h8000_1000);
        wait_req(1'b1, 20, "rw_next");
        total++;
        if (r_addr !== 64'h8000_1000) begin
            bad++;
            $display("FAIL rw_addr got %h want %h", r_addr, 64'h8000_1000);
        end
        f0 = n_fire;
        repeat (10) step(1'b1, 1'b0, '0);
        total++;
        if (n_fire - f0 < 2) begin
            bad++;
            $display("FAIL rw_stream got %0d want >=2", n_fire - f0);
        end
    endtask

    task automatic test_fault();
        int f0, q0;
        err_en = 1'b1; err_addr = 64'h8000_0008;
        lat_min = 1; lat_max = 3; rdy_pct = 70;
        f0 = n_fault;
        step(1'b1, 1'b1, RPC);
        repeat (30) step(1'($urandom_range(0, 1)), 1'b0, '0);
        repeat (5) step(1'b1, 1'b0, '0);
        q0 = n_req;
        repeat (10) step(1'b1, 1'b0, '0);
        total++;
        if (n_fault - f0 != 1 || last_pc !== 64'h8000_0008) begin
            bad++;
            $display("FAIL fault_entry got faults=%0d last_pc=%h want 1 %h", n_fault - f0, last_pc, 64'h8000_0008);
        end
        total++;
        if (n_req != q0 || r_valid !== 1'b0) begin
            bad++;
            $display("FAIL fault_halt got reqs=%0d req_valid=%b want 0 0", n_req - q0, r_valid);
        end
        err_en = 1'b0;
    endtask

    task automatic test_misaligned();
        int f0, q0;
        lat_min = 1; lat_max = 1; rdy_pct = 100;
        f0 = n_fault;
        q0 = n_req;
        step(1'b1, 1'b1, 64'h8000_0102);
        repeat (8) step(1'b1, 1'b0, '0);
        total++;
        if (n_fault - f0 != 1 || last_pc !== 64'h8000_0102) begin
            bad++;
            $display("FAIL mis_entry got faults=%0d last_pc=%h want 1 %h", n_fault - f0, last_pc, 64'h8000_0102);
        end
        total++;
        if (n_req != q0 || r_valid !== 1'b0) begin
            bad++;
            $display("FAIL mis_halt got reqs=%0d req_valid=%b want 0 0", n_req - q0, r_valid);
        end
        step(1'b1, 1'b1, 64'h8000_0200);
        wait_req(1'b1, 10, "mis_resume");
        total++;
        if (r_addr !== 64'h8000_0200) begin
            bad++;
            $display("FAIL mis_resume_addr got %h want %h", r_addr, 64'h8000_0200);
        end
        repeat (10) step(1'b1, 1'b0, '0);
    endtask

    task automatic test_random();
        int f0;
        logic [63:0] tgt;
        lat_min = 1; lat_max = 3; rdy_pct = 60;
        err_en = 1'b1;
        err_addr = RPC + 64'(4 * $urandom_range(8, 40));
        f0 = n_fire;
        for (int i = 0; i < 400; i++) begin
            tgt = RPC + 64'(4 * $urandom_range(0, 48));
            if ($urandom_range(0, 9) == 0) tgt = tgt + 64'($urandom_range(1, 3));
            step(1'(int'($urandom_range(0, 99)) < 70),
                 1'(int'($urandom_range(0, 99)) < 4), tgt);
        end
        step(1'b1, 1'b1, RPC);
        err_en = 1'b0;
        total++;
        if (n_fire - f0 < 20) begin
            bad++;
            $display("FAIL random_progress got %0d want >=20", n_fire - f0);
        end
    endtask

    task automatic test_reset_midwait();
        int k, f0;
        lat_min = 5; lat_max = 5; rdy_pct = 100;
        step(1'b0, 1'b1, RPC);
        k = 0;
        do begin
            step(1'b0, 1'b0, '0);
            k++;
        end while (!(o_valid && pend) && k < 30);
        total++;
        if (!(o_valid && pend)) begin
            bad++;
            $display("FAIL rst_setup got out_valid=%b outstanding=%0b want 1 1", o_valid, pend);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || imem_req_valid !== 1'b0 || out_pc !== 64'h0
            || out_inst !== 32'h0 || out_fault !== 1'b0) begin
            bad++;
            $display("FAIL rst_async got out_valid=%b req=%b pc=%h inst=%h fault=%b want zeros",
                     out_valid, imem_req_valid, out_pc, out_inst, out_fault);
        end
        exp_pc = RPC; req_exp = RPC;
        model_halt = 1'b0; req_blocked = 1'b0;
        mem_block = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        k = 0;
        do begin
            step(1'b1, 1'b0, '0);
            k++;
        end while (pend && k < 10);
        mem_block = 1'b0;
        lat_min = 1; lat_max = 1;
        wait_req(1'b1, 10, "rst_first");
        total++;
        if (r_addr !== RPC) begin
            bad++;
            $display("FAIL rst_addr got %h want %h", r_addr, RPC);
        end
        f0 = n_fire;
        repeat (12) step(1'b1, 1'b0, '0);
        total++;
        if (n_fire - f0 < 3) begin
            bad++;
            $display("FAIL rst_stream got %0d want >=3", n_fire - f0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
        imem_resp_data = '0; imem_resp_err = 1'b0;
        out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        pend = 1'b0; pend_addr = '0; pend_cnt = 0;
        mem_block = 1'b0; err_en = 1'b0; err_addr = '0;
        exp_pc = RPC; req_exp = RPC; model_halt = 1'b0; req_blocked = 1'b0;
        last_pc = '0; n_fire = 0; n_req = 0; n_fault = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_fault();
        test_misaligned();
        test_random();
        test_reset_midwait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ysyx_22050612_fetch_unit.md
Name: ysyx_22050612_fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the execute unit. It owns the fetch PC and issues 4-byte instruction reads to instruction memory over a valid/ready request channel and a valid-only response channel. It buffers returned instructions in a small FIFO and presents {pc, inst, fault} to decode/execute over a valid/ready handshake. Execute-stage control flow (jal/jalr/branch dnpc != pc+4) arrives as a redirect that flushes all in-flight work.

Parameters:
RESET_PC, 64'h8000_0000, fetch PC after reset
DEPTH, 2, instruction FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  64  fetch address, always 4-byte aligned
imem_resp_valid  in  1  response valid, exactly one per accepted request, >=1 cycle after acceptance
imem_resp_data  in  32  instruction word
imem_resp_err  in  1  access fault for this response
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream consumes head
out_pc  out  64  PC of head instruction
out_inst  out  32  head instruction
out_fault  out  1  head is a fetch fault, inst = 0
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  64  new fetch PC

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, state=S_REQ, FIFO empty, epoch drop flag 0; imem_req_valid=0, out_valid=0, out_pc=0, out_inst=0, out_fault=0.
- FSM states: S_REQ, S_WAIT, S_DISCARD, S_HALT.
- S_REQ: imem_req_valid = (fifo_count < DEPTH) && !redirect_valid. The redirect mask is combinational. imem_req_addr = fetch_pc. On accept (valid&&ready) go to S_WAIT and latch req_pc = fetch_pc, fetch_pc += 4 (64-bit wrap, no saturation).
- S_WAIT: on imem_resp_valid push {req_pc, resp_data, resp_err} into the FIFO. Space is guaranteed by the issue rule. If resp_err, push inst=0, fault=1 and go to S_HALT; else go to S_REQ. At most one outstanding request at any time.
- S_HALT: no requests; waits for redirect.
- S_DISCARD: waits for the single stale response, drops it, then goes to S_REQ.
- Redirect (any state, highest priority) at the clock edge:
  - FIFO flushed; fetch_pc = {redirect_pc[63:2], 2'b00}.
  - If a request is outstanding and its response is not arriving this same cycle, go to S_DISCARD.
  - If that response arrives this cycle, drop it and go to S_REQ.
  - Otherwise go to S_REQ.
- Redirect with redirect_pc[1:0] != 0: the FIFO is loaded with one entry {redirect_pc, 0, fault=1} and the FSM goes to S_HALT after any needed discard.
- FIFO:
  - out_* reflect the head; an entry written at edge N is visible at out_valid in cycle N+1. Min latency from request accept to out_valid is 2 cycles when the response comes the next cycle.
  - Push and pop in the same cycle are allowed, including when full (pop frees the slot only next cycle for issue purposes).
  - out handshake in the same cycle as redirect completes normally (the consumer has taken it); flush applies after.
  - out_valid must not depend combinationally on out_ready. Head data stable while out_valid && !out_ready.
- imem_resp_valid in S_REQ or S_HALT (protocol violation) is ignored.

Decomposition:
- Shared package ysyx_22050612_pkg: XLEN=64, ILEN=32, RESET_PC default, FSM state encoding (2-bit), fetch entry struct/width constant {pc, inst, fault}.
- One natural sub-module: ysyx_22050612_sync_fifo (parameterised width/depth, flush input, full/empty/count outputs), reusable by a later LSU buffer.

Test Plan:
- Reset then memory always ready with 1-cycle response: out stream pc=0x80000000, 0x80000004, 0x80000008 with matching inst words; first out_valid 2 cycles after first accept.
- out_ready=0 for 10 cycles: FIFO holds exactly DEPTH=2 entries, imem_req_valid=0 while full, no response lost; release yields in-order pcs.
- Redirect to 0x80001000 while in S_WAIT, stale response 3 cycles later: stale word never appears on out; next request addr=0x80001000.
- Response with imem_resp_err=1 at pc 0x80000008: out shows pc=0x80000008, fault=1, inst=0; no further requests until redirect.
- Redirect to 0x80000102 (misaligned): single fault entry pc=0x80000102, then halt; a following redirect to 0x80000200 resumes fetching.
- rst_n asserted mid-S_WAIT with out_valid high: outputs zero immediately (async); after release first request addr=RESET_PC, late stale response ignored.
